// File: rtl/code_lock_fsm_pkg.sv
// Shared definitions for the keypad code-lock checker.
package code_lock_fsm_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  // Width of one BCD keypad digit.
  localparam int BCD_DW  = 4;
  // Largest digit value accepted from the keypad.
  localparam int BCD_MAX = 9;

endpackage

// File: rtl/code_lock_fsm_digit_shift_reg.sv
// Entry buffer: shifts accepted digits in at the LS end and counts them.
module digit_shift_reg
  import code_lock_fsm_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DW     = BCD_DW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          clr,
  input  logic [DW-1:0]                 din,
  output logic [DIGITS*DW-1:0]          buffer,
  output logic [$clog2(DIGITS+1)-1:0]   cnt
);

  localparam int BW = DIGITS * DW;
  localparam int CW = $clog2(DIGITS + 1);

  // Clear has priority over load; the count saturates at DIGITS.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      buffer <= '0;
      cnt    <= '0;
    end else if (load && (cnt != CW'(DIGITS))) begin
      buffer <= BW'({buffer, din});
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/code_lock_fsm.sv
// Code-entry checker: collects DIGITS BCD digits, compares them against
// PASSWORD and drives unlock / fail / lockout status downstream.
//
// state      | meaning
// ENTRY      | collecting digits from the keypad
// CHECK      | one cycle comparing the full buffer with PASSWORD
// OPEN       | correct code, unlocked until clear
// FAIL       | one cycle wrong-code pulse, buffer cleared
// LOCKOUT    | too many wrong codes, inputs ignored for LOCK_CYCLES
module code_lock_fsm
  import code_lock_fsm_pkg::*;
#(
  parameter int                      DIGITS      = 4,
  parameter int                      DW          = BCD_DW,
  parameter logic [DIGITS*DW-1:0]    PASSWORD    = 16'h1234,
  parameter int                      MAX_FAIL    = 3,
  parameter int                      LOCK_CYCLES = 100000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            digit_valid,
  input  logic [DW-1:0]                   digit,
  input  logic                            clear,
  output logic [DIGITS*DW-1:0]            code_disp,
  output logic [$clog2(DIGITS+1)-1:0]     entry_cnt,
  output logic                            unlocked,
  output logic                            fail,
  output logic                            locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(LOCK_CYCLES);

  state_t          state;
  logic [TW-1:0]   timer;
  logic            accept;
  logic            buf_clr;
  logic            match;
  logic [DIGITS*DW-1:0] buffer;
  logic [CW-1:0]   cnt;

  // A digit is taken only while collecting, only if it is a real BCD value,
  // and never in the same cycle as an abort.
  assign accept  = (state == ST_ENTRY) && digit_valid && !clear &&
                   (digit <= DW'(BCD_MAX));

  // Buffer is wiped on abort, on relock, after a wrong code and at lockout end.
  assign buf_clr = ((state == ST_ENTRY) && clear) ||
                   ((state == ST_OPEN) && clear) ||
                   (state == ST_FAIL) ||
                   ((state == ST_LOCKOUT) && (timer == '0));

  // Comparison of the registered buffer; only consumed in CHECK.
  assign match = &(buffer ~^ PASSWORD);

  digit_shift_reg #(
    .DIGITS (DIGITS),
    .DW     (DW)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .clr    (buf_clr),
    .din    (digit),
    .buffer (buffer),
    .cnt    (cnt)
  );

  assign code_disp = buffer;
  assign entry_cnt = cnt;

  // Sequencing, failure counting, lockout timer and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ENTRY;
      unlocked <= 1'b0;
      fail     <= 1'b0;
      locked   <= 1'b0;
      fail_cnt <= '0;
      timer    <= '0;
    end else begin
      fail <= 1'b0;
      case (state)
        ST_ENTRY: begin
          if (accept && (cnt == CW'(DIGITS - 1))) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (match) begin
            fail_cnt <= '0;
            unlocked <= 1'b1;
            state    <= ST_OPEN;
          end else if (fail_cnt == FW'(MAX_FAIL - 1)) begin
            fail_cnt <= FW'(MAX_FAIL);
            timer    <= TW'(LOCK_CYCLES - 1);
            locked   <= 1'b1;
            fail     <= 1'b1;
            state    <= ST_LOCKOUT;
          end else begin
            fail_cnt <= fail_cnt + FW'(1);
            fail     <= 1'b1;
            state    <= ST_FAIL;
          end
        end
        ST_OPEN: begin
          if (clear) begin
            unlocked <= 1'b0;
            state    <= ST_ENTRY;
          end
        end
        ST_FAIL: begin
          state <= ST_ENTRY;
        end
        ST_LOCKOUT: begin
          if (timer == '0) begin
            fail_cnt <= '0;
            locked   <= 1'b0;
            state    <= ST_ENTRY;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state <= ST_ENTRY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm: vector table, hand-written corner sequences and
// randomized traffic checked against a behavioural model.
module tb_code_lock_fsm;

  localparam int          DIGITS   = 4;
  localparam int          DW       = 4;
  localparam logic [15:0] PW       = 16'h1234;
  localparam int          MAXF     = 3;
  localparam int          LOCKC    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = '0;
  logic        clear = 1'b0;
  logic [15:0] code_disp;
  logic [2:0]  entry_cnt;
  logic        unlocked;
  logic        fail;
  logic        locked;
  logic [1:0]  fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  code_lock_fsm #(
    .DIGITS      (DIGITS),
    .DW          (DW),
    .PASSWORD    (PW),
    .MAX_FAIL    (MAXF),
    .LOCK_CYCLES (LOCKC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (digit_valid),
    .digit       (digit),
    .clear       (clear),
    .code_disp   (code_disp),
    .entry_cnt   (entry_cnt),
    .unlocked    (unlocked),
    .fail        (fail),
    .locked      (locked),
    .fail_cnt    (fail_cnt)
  );

  // Behavioural model: the entered digits as a queue plus a few phase flags.
  int m_q[$];
  bit m_checking, m_open, m_failing, m_fail_out;
  int m_lock_left;
  int m_fails;

  function automatic int m_code();
    int c = 0;
    foreach (m_q[i]) c = (c << 4) | m_q[i];
    return c;
  endfunction

  task automatic model_update(input bit r, input bit dv, input int d, input bit c);
    if (r) begin
      m_q.delete();
      m_checking = 0; m_open = 0; m_failing = 0; m_fail_out = 0;
      m_lock_left = 0; m_fails = 0;
      return;
    end
    m_fail_out = 0;
    if (m_checking) begin
      m_checking = 0;
      if (m_code() == int'(PW)) begin
        m_fails = 0;
        m_open  = 1;
      end else begin
        m_fails    = m_fails + 1;
        m_fail_out = 1;
        if (m_fails >= MAXF) m_lock_left = LOCKC;
        else m_failing = 1;
      end
    end else if (m_open) begin
      if (c) begin
        m_open = 0;
        m_q.delete();
      end
    end else if (m_failing) begin
      m_failing = 0;
      m_q.delete();
    end else if (m_lock_left > 0) begin
      m_lock_left = m_lock_left - 1;
      if (m_lock_left == 0) begin
        m_fails = 0;
        m_q.delete();
      end
    end else begin
      if (c) m_q.delete();
      else if (dv && d <= 9) begin
        m_q.push_back(d);
        if (m_q.size() == DIGITS) m_checking = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("model_code_disp", 32'(code_disp), 32'(m_code()));
    chk("model_entry_cnt", 32'(entry_cnt), 32'(m_q.size()));
    chk("model_unlocked",  32'(unlocked),  32'(m_open));
    chk("model_fail",      32'(fail),      32'(m_fail_out));
    chk("model_locked",    32'(locked),    32'(m_lock_left > 0));
    chk("model_fail_cnt",  32'(fail_cnt),  32'(m_fails));
  endtask

  // One clock: drive inputs, advance model on the edge, compare just after it.
  task automatic step(input bit r, input bit dv, input logic [3:0] d, input bit c);
    rst = r; digit_valid = dv; digit = d; clear = c;
    @(posedge clk);
    model_update(r, dv, int'(d), c);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 0);
  endtask

  task automatic enter_code(input logic [15:0] code, input int gap);
    for (int i = 0; i < DIGITS; i++) begin
      step(0, 1, code[15-4*i -: 4], 0);
      if (i != DIGITS - 1) idle(gap);
    end
  endtask

  typedef struct {
    bit          r;
    bit          dv;
    logic [3:0]  d;
    bit          c;
    bit          unl;
    bit          fl;
    bit          lk;
    int          ecnt;
    int          fcnt;
    logic [15:0] code;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int lk_cycles;
    bit seen;

    //           r dv  d    c  unl fl lk ecnt fcnt code
    vecs[0]  = '{1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 16'h0000};
    vecs[1]  = '{0, 1, 4'h1, 0, 0, 0, 0, 1, 0, 16'h0001};
    vecs[2]  = '{0, 1, 4'h2, 0, 0, 0, 0, 2, 0, 16'h0012};
    vecs[3]  = '{0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 16'h0000};
    vecs[4]  = '{0, 1, 4'h7, 1, 0, 0, 0, 0, 0, 16'h0000};
    vecs[5]  = '{0, 1, 4'hA, 0, 0, 0, 0, 0, 0, 16'h0000};
    vecs[6]  = '{0, 1, 4'h1, 0, 0, 0, 0, 1, 0, 16'h0001};
    vecs[7]  = '{0, 1, 4'hA, 0, 0, 0, 0, 1, 0, 16'h0001};
    vecs[8]  = '{0, 1, 4'h2, 0, 0, 0, 0, 2, 0, 16'h0012};
    vecs[9]  = '{0, 1, 4'h3, 0, 0, 0, 0, 3, 0, 16'h0123};
    vecs[10] = '{0, 1, 4'h4, 0, 0, 0, 0, 4, 0, 16'h1234};
    vecs[11] = '{0, 1, 4'h5, 0, 1, 0, 0, 4, 0, 16'h1234};
    vecs[12] = '{0, 1, 4'h6, 0, 1, 0, 0, 4, 0, 16'h1234};
    vecs[13] = '{0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 16'h0000};
    vecs[14] = '{0, 1, 4'h1, 0, 0, 0, 0, 1, 0, 16'h0001};
    vecs[15] = '{0, 1, 4'h2, 0, 0, 0, 0, 2, 0, 16'h0012};
    vecs[16] = '{0, 1, 4'h3, 0, 0, 0, 0, 3, 0, 16'h0123};
    vecs[17] = '{0, 1, 4'h5, 0, 0, 0, 0, 4, 0, 16'h1235};
    vecs[18] = '{0, 0, 4'h0, 0, 0, 1, 0, 4, 1, 16'h1235};
    vecs[19] = '{0, 1, 4'h9, 0, 0, 0, 0, 0, 1, 16'h0000};
    vecs[20] = '{0, 1, 4'h1, 0, 0, 0, 0, 1, 1, 16'h0001};

    step(1, 0, 4'h0, 0);
    step(1, 0, 4'h0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].dv, vecs[i].d, vecs[i].c);
      chk($sformatf("vec%0d_unlocked", i),  32'(unlocked),  32'(vecs[i].unl));
      chk($sformatf("vec%0d_fail", i),      32'(fail),      32'(vecs[i].fl));
      chk($sformatf("vec%0d_locked", i),    32'(locked),    32'(vecs[i].lk));
      chk($sformatf("vec%0d_entry_cnt", i), 32'(entry_cnt), 32'(vecs[i].ecnt));
      chk($sformatf("vec%0d_fail_cnt", i),  32'(fail_cnt),  32'(vecs[i].fcnt));
      chk($sformatf("vec%0d_code_disp", i), 32'(code_disp), 32'(vecs[i].code));
    end

    // Correct code with strobes three cycles apart, then relock.
    step(1, 0, 4'h0, 0);
    enter_code(16'h1234, 2);
    chk("spaced_check_cycle_unlocked", 32'(unlocked), 32'd0);
    step(0, 0, 4'h0, 0);
    chk("spaced_unlocked", 32'(unlocked), 32'd1);
    chk("spaced_code", 32'(code_disp), 32'h1234);
    chk("spaced_fail_cnt", 32'(fail_cnt), 32'd0);
    step(0, 0, 4'h0, 1);
    chk("relock_unlocked", 32'(unlocked), 32'd0);
    chk("relock_entry_cnt", 32'(entry_cnt), 32'd0);

    // Lockout: third wrong code locks for exactly LOCKC cycles, digits ignored.
    for (int k = 0; k < MAXF; k++) begin
      enter_code(16'h1235, 0);
      step(0, 0, 4'h0, 0);
      chk($sformatf("wrong%0d_fail_pulse", k), 32'(fail), 32'd1);
      if (k < MAXF - 1) idle(2);
    end
    chk("lock_entry_locked", 32'(locked), 32'd1);
    chk("lock_fail_cnt", 32'(fail_cnt), 32'(MAXF));
    lk_cycles = 1;
    for (int i = 0; i < 20 && locked; i++) begin
      step(0, 1, 4'(PW[15-4*(i%4) -: 4]), i[0]);
      if (locked) lk_cycles++;
    end
    chk("lock_cycles", 32'(lk_cycles), 32'(LOCKC));
    chk("lock_end_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("lock_end_entry_cnt", 32'(entry_cnt), 32'd0);
    enter_code(16'h1234, 0);
    step(0, 0, 4'h0, 0);
    chk("post_lock_unlocked", 32'(unlocked), 32'd1);

    // Reset while OPEN.
    step(1, 0, 4'h0, 0);
    chk("rst_open_unlocked", 32'(unlocked), 32'd0);
    chk("rst_open_code", 32'(code_disp), 32'd0);

    // Reset when the lockout timer has reached 3.
    for (int k = 0; k < MAXF; k++) begin
      enter_code(16'h9999, 0);
      idle(2);
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (locked) seen = 1;
      else step(0, 0, 4'h0, 0);
    end
    chk("rst_lock_reached", 32'(locked), 32'd1);
    idle(LOCKC - 4 - 1);
    chk("rst_lock_still_locked", 32'(locked), 32'd1);
    step(1, 1, 4'h1, 1);
    chk("rst_lock_locked", 32'(locked), 32'd0);
    chk("rst_lock_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_lock_entry_cnt", 32'(entry_cnt), 32'd0);
    chk("rst_lock_fail", 32'(fail), 32'd0);

    // Randomized traffic, biased toward the password so every state is visited.
    for (int i = 0; i < 4000; i++) begin
      bit r, dv, c;
      logic [3:0] d;
      r  = ($urandom_range(0, 299) == 0);
      dv = ($urandom_range(0, 1) == 1);
      c  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) != 0 && m_q.size() < DIGITS)
        d = PW[15-4*m_q.size() -: 4];
      else
        d = 4'($urandom_range(0, 11));
      step(r, dv, d, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
